// File: rtl/axis_arb_pkg.sv
// Shared types and sizing helpers for the AXI-Stream frame arbiter family.
package axis_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int DEF_S_COUNT    = 4;
  localparam int DEF_DATA_WIDTH = 32;

  // Index width for S_COUNT ports; a single-port index still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin picker: the first set bit of req, searching upward from
// last_grant+1 modulo S_COUNT. Zero latency, no state, no backpressure.
module axis_rr_select #(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = 2
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % S_COUNT);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-locked round-robin AXI-Stream arbiter with a registered output stage; grant one cycle
// after request, beat visible one cycle after transfer. Optional m_axis_tid via AXIS_ARB_TID_EN.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int S_COUNT    = DEF_S_COUNT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = id_width(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
`ifdef AXIS_ARB_TID_EN
  output logic [ID_WIDTH-1:0]           m_axis_tid,
`endif
  output logic [S_COUNT-1:0]            status_grant,
  output logic                          status_busy
);

  arb_state_t            state, state_next;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   last_grant;
  logic                  pick_vld;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  out_free;
  logic                  take;
  logic [DATA_WIDTH-1:0] sel_data;

  axis_rr_select #(
    .S_COUNT (S_COUNT),
    .IDX_W   (ID_WIDTH)
  ) u_rr_select (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  // The output register can accept a beat when empty or draining this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    state_next    = state;
    s_axis_tready = '0;
    take          = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_next = ACTIVE;
      end
      ACTIVE: begin
        s_axis_tready[grant_idx] = out_free;
        take = s_axis_tvalid[grant_idx] && out_free;
        if (take && s_axis_tlast[grant_idx]) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_idx == ID_WIDTH'(i)) sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_idx     <= '0;
      last_grant    <= ID_WIDTH'(S_COUNT - 1);
      m_axis_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_vld) grant_idx <= pick_idx;
      if (take && s_axis_tlast[grant_idx]) last_grant <= grant_idx;
      if (take) begin
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  // Payload carries no reset; it is only meaningful while m_axis_tvalid is high.
  always_ff @(posedge clk) begin
    if (take) begin
      m_axis_tdata <= sel_data;
      m_axis_tlast <= s_axis_tlast[grant_idx];
`ifdef AXIS_ARB_TID_EN
      m_axis_tid   <= grant_idx;
`endif
    end
  end

  always_comb begin
    status_grant = '0;
    if (state == ACTIVE) status_grant[grant_idx] = 1'b1;
  end

  assign status_busy = (state == ACTIVE);

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomised and directed bench for axis_frame_arbiter against a frame-level arbitration model.
module tb_axis_frame_arbiter;
  localparam int S  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0]   m_axis_tid;
`endif
  logic [S-1:0]    status_grant;
  logic            status_busy;

  always #5 clk = ~clk;

  axis_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
`ifdef AXIS_ARB_TID_EN
    .m_axis_tid(m_axis_tid),
`endif
    .status_grant(status_grant), .status_busy(status_busy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0] srcq [S][$];   // {last, data} beats waiting at each source
  logic [S-1:0] en;
  logic [DW:0] olog [$];      // beats seen leaving m_axis
  int          glog [$];      // ports granted, in order
  logic        prev_busy;

  // Model: frame owner, rotation pointer and the one-deep output register.
  bit          mb;
  int          mown, mlast, mo_id;
  bit          mo_vld, mo_last;
  logic [DW-1:0] mo_dat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb = 0; mown = 0; mlast = S - 1; mo_vld = 0; mo_last = 0; mo_dat = '0; mo_id = 0;
  endtask

  task automatic drive();
    logic [DW:0] h;
    for (int i = 0; i < S; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        h = srcq[i][0];
        s_axis_tvalid[i] = 1'b1;
        s_axis_tdata[i*DW +: DW] = h[DW-1:0];
        s_axis_tlast[i] = h[DW];
      end else begin
        s_axis_tvalid[i] = 1'b0;
        s_axis_tdata[i*DW +: DW] = $urandom;
        s_axis_tlast[i] = 1'($urandom);
      end
    end
  endtask

  // One clock: drive at negedge, compare, then advance sources and model across the posedge.
  task automatic cycle();
    logic [S-1:0] exp_g, exp_r, vld, rdy, lst;
    logic [S*DW-1:0] dat;
    logic mrdy, mv, ml, ok;
    logic [DW-1:0] md;
    int p;
    drive();
    #1;
    exp_g = '0;
    if (mb) exp_g[mown] = 1'b1;
    ok = !mo_vld || m_axis_tready;
    exp_r = '0;
    if (mb && ok) exp_r[mown] = 1'b1;
    chk("busy", status_busy, mb);
    chk("grant", status_grant, exp_g);
    chk("s_rdy", s_axis_tready, exp_r);
    chk("m_vld", m_axis_tvalid, mo_vld);
    if (mo_vld) begin
      chk("m_dat", m_axis_tdata, mo_dat);
      chk("m_last", m_axis_tlast, mo_last);
`ifdef AXIS_ARB_TID_EN
      chk("m_tid", m_axis_tid, mo_id);
`endif
    end
    if (status_busy && !prev_busy)
      for (int i = 0; i < S; i++) if (status_grant[i]) glog.push_back(i);
    prev_busy = status_busy;
    vld = s_axis_tvalid; rdy = s_axis_tready; lst = s_axis_tlast; dat = s_axis_tdata;
    mrdy = m_axis_tready; mv = m_axis_tvalid; ml = m_axis_tlast; md = m_axis_tdata;
    @(posedge clk);
    if (mv && mrdy) olog.push_back({ml, md});
    for (int i = 0; i < S; i++) if (vld[i] && rdy[i]) void'(srcq[i].pop_front());
    if (!mb) begin
      if (mrdy) mo_vld = 0;
      if (|vld) begin
        for (int k = 1; k <= S; k++) begin
          p = (mlast + k) % S;
          if (vld[p]) begin mown = p; mb = 1; break; end
        end
      end
    end else if (vld[mown] && ok) begin
      mo_vld = 1; mo_dat = dat[mown*DW +: DW]; mo_last = lst[mown]; mo_id = mown;
      if (lst[mown]) begin mb = 0; mlast = mown; end
    end else if (mrdy) begin
      mo_vld = 0;
    end
    @(negedge clk);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < S; i++) if (srcq[i].size() > 0) return 0;
    return !status_busy && !m_axis_tvalid;
  endfunction

  task automatic drain(input int max);
    bit done = 0;
    en = '1;
    m_axis_tready = 1'b1;
    for (int n = 0; n < max && !done; n++) begin
      if (all_idle()) done = 1;
      else cycle();
    end
    if (!done) done = all_idle();
    chk("drain_timeout", done, 1);
  endtask

  // Asserts reset between clock edges and checks that outputs drop with no edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_vld", m_axis_tvalid, 0);
    chk("rst_s_rdy", s_axis_tready, 0);
    chk("rst_grant", status_grant, 0);
    chk("rst_busy", status_busy, 0);
    model_reset();
    for (int i = 0; i < S; i++) srcq[i].delete();
    en = '0;
    prev_busy = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [DW:0] bt(input logic l, input logic [DW-1:0] d);
    return {l, d};
  endfunction

  initial begin
    logic [DW:0] expq [$];
    int fno;
    int p, len;
    en = '0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0;
    prev_busy = 0;
    model_reset();
    @(negedge clk);
    chk("reset_m_vld", m_axis_tvalid, 0);
    chk("reset_s_rdy", s_axis_tready, 0);
    chk("reset_grant", status_grant, 0);
    chk("reset_busy", status_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 3-beat frame on port 2.
    srcq[2].push_back(bt(0, 32'hA0));
    srcq[2].push_back(bt(0, 32'hA1));
    srcq[2].push_back(bt(1, 32'hA2));
    en = 4'b0100;
    cycle();
    chk("t1_grant", status_grant, 4'b0100);
    drain(30);
    chk("t1_cnt", olog.size(), 3);
    chk("t1_b0", olog[0], {1'b0, 32'hA0});
    chk("t1_b1", olog[1], {1'b0, 32'hA1});
    chk("t1_b2", olog[2], {1'b1, 32'hA2});
    chk("t1_idle", status_busy, 0);

    // All four ports, two 2-beat frames each, from reset priority.
    do_reset();
    olog.delete(); glog.delete();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < S; q++) begin
        srcq[q].push_back(bt(0, 32'hB000_0000 | (q << 8) | (r << 4)));
        srcq[q].push_back(bt(1, 32'hB000_0000 | (q << 8) | (r << 4) | 1));
      end
    drain(100);
    chk("t2_gcnt", glog.size(), 8);
    chk("t2_g0", glog[0], 0);
    chk("t2_g1", glog[1], 1);
    chk("t2_g2", glog[2], 2);
    chk("t2_g3", glog[3], 3);
    chk("t2_g4", glog[4], 0);
    chk("t2_bcnt", olog.size(), 16);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < S; q++)
        for (int b = 0; b < 2; b++)
          chk("t2_order", olog[r*8 + q*2 + b],
              {b[0], 32'hB000_0000 | (q << 8) | (r << 4) | b});

    // Rotation: port 1 alone, then ports 0, 1, 3 together -> 3, 0, 1.
    glog.delete();
    srcq[1].push_back(bt(1, 32'h11));
    drain(20);
    srcq[0].push_back(bt(1, 32'h20));
    srcq[1].push_back(bt(1, 32'h21));
    srcq[3].push_back(bt(1, 32'h23));
    drain(30);
    chk("rot_cnt", glog.size(), 4);
    chk("rot_0", glog[0], 1);
    chk("rot_1", glog[1], 3);
    chk("rot_2", glog[2], 0);
    chk("rot_3", glog[3], 1);

    // Frame lock: port 1 stalls mid-frame while port 0 waits.
    glog.delete(); olog.delete();
    srcq[1].push_back(bt(0, 32'hC0));
    srcq[1].push_back(bt(0, 32'hC1));
    srcq[1].push_back(bt(1, 32'hC2));
    srcq[0].push_back(bt(0, 32'hD0));
    srcq[0].push_back(bt(1, 32'hD1));
    en = 4'b0010;
    for (int n = 0; n < 5 && !status_busy; n++) cycle();
    chk("t3_grant1", status_grant, 4'b0010);
    cycle();
    en = 4'b0001;
    repeat (5) begin
      cycle();
      chk("t3_lock_rdy0", s_axis_tready[0], 0);
      chk("t3_lock_grant", status_grant, 4'b0010);
    end
    drain(30);
    chk("t3_gcnt", glog.size(), 2);
    chk("t3_g0", glog[0], 1);
    chk("t3_g1", glog[1], 0);
    chk("t3_bcnt", olog.size(), 5);
    chk("t3_b0", olog[0], {1'b0, 32'hC0});
    chk("t3_b2", olog[2], {1'b1, 32'hC2});
    chk("t3_b3", olog[3], {1'b0, 32'hD0});

    // Downstream stall for four cycles in the middle of a frame.
    olog.delete();
    for (int b = 0; b < 6; b++) srcq[2].push_back(bt(b == 5, 32'hE0 + b));
    en = 4'b0100;
    m_axis_tready = 1'b1;
    repeat (3) cycle();
    m_axis_tready = 1'b0;
    repeat (4) begin
      cycle();
      chk("t4_hold_vld", m_axis_tvalid, 1);
      chk("t4_hold_dat", m_axis_tdata, 32'hE1);
      chk("t4_hold_last", m_axis_tlast, 0);
      chk("t4_stall_rdy", s_axis_tready, 0);
    end
    drain(30);
    chk("t4_bcnt", olog.size(), 6);
    for (int b = 0; b < 6; b++) chk("t4_sb", olog[b], {b == 5, 32'hE0 + b});

    // Asynchronous reset in the middle of a frame, then port 0 first.
    for (int b = 0; b < 8; b++) srcq[3].push_back(bt(b == 7, 32'hF0 + b));
    en = 4'b1000;
    repeat (3) cycle();
    chk("t5_pre_vld", m_axis_tvalid, 1);
    do_reset();
    glog.delete();
    for (int q = 0; q < S; q++) srcq[q].push_back(bt(1, 32'h50 + q));
    drain(40);
    chk("t5_gcnt", glog.size(), 4);
    chk("t5_first", glog[0], 0);
    chk("t5_second", glog[1], 1);

    // Random traffic with random source gaps and downstream backpressure.
    fno = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) begin
        p = $urandom_range(S - 1);
        len = $urandom_range(1, 4);
        if (srcq[p].size() < 12) begin
          for (int b = 0; b < len; b++)
            srcq[p].push_back(bt(b == len - 1, {8'(p), 8'(fno), 16'($urandom)}));
          fno++;
        end
      end
      for (int i = 0; i < S; i++) en[i] = ($urandom_range(4) != 0);
      m_axis_tready = ($urandom_range(3) != 0);
      cycle();
    end
    drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
